// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch with one outstanding read
// and a small FIFO of fetched words handed to the decoder.
module instr_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] pc_in,
    input  logic        pc_in_valid,
    output logic        pc_in_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    output logic        instr_valid,
    output logic [0:31] instr,
    output logic [0:31] instr_pc,
    output logic        instr_err,
    input  logic        instr_ready
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [0:31] pc;
        logic [0:31] word;
        logic        err;
    } entry_t;

    state_t      state;
    logic [0:31] cap_pc;
    logic        req_q;

    entry_t      mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          outstanding;
    logic [CW-1:0] slots;
    logic          accept;
    logic          aligned;
    logic          mem_push;
    logic          err_push;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;

    // Slot reservation: an in-flight read owns a buffer slot.
    always_comb begin
        outstanding = (state != IDLE);
        slots       = count + CW'(outstanding);
        pc_in_ready = (state == IDLE) && !flush
                      && (slots < CW'(FIFO_DEPTH));
        accept      = pc_in_valid && pc_in_ready;
        aligned     = (pc_in[30:31] == 2'b00);
        mem_push    = (state == WAIT) && imem_rvalid && !flush;
        err_push    = accept && !aligned;
        push        = mem_push || err_push;
        pop         = instr_valid && instr_ready && !flush;
        if (mem_push) begin
            push_entry = '{pc: cap_pc, word: imem_rdata, err: 1'b0};
        end else begin
            push_entry = '{pc: pc_in, word: '0, err: 1'b1};
        end
    end

    // Fetch FSM: one request at a time, flush drains a granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cap_pc <= '0;
            req_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && aligned) begin
                        cap_pc <= pc_in;
                        req_q  <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        req_q <= 1'b0;
                        state <= imem_gnt ? DRAIN : IDLE;
                    end else if (imem_gnt) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer pointers and count; flush empties it ahead of push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Head entry drives the decoder outputs, zero when empty.
    always_comb begin
        head        = mem[rd_ptr];
        instr_valid = (count != '0);
        instr       = instr_valid ? head.word : '0;
        instr_pc    = instr_valid ? head.pc : '0;
        instr_err   = instr_valid && head.err;
        imem_req    = req_q;
        imem_addr   = cap_pc;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch latency, backpressure,
// grant stall, flush, misaligned PC and reset behaviour.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] pc_in;
    logic        pc_in_valid;
    logic        pc_in_ready;
    logic        flush;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;
    logic        instr_valid;
    logic [0:31] instr;
    logic [0:31] instr_pc;
    logic        instr_err;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;

    instr_fetch #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_in_valid(pc_in_valid),
        .pc_in_ready(pc_in_ready),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_err  (instr_err),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Count accepted memory requests.
    always @(posedge clk) begin
        if (!rst && imem_req && imem_gnt) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    // Minimum-latency aligned fetch: accept, gnt next, rvalid after.
    task automatic fetch(input logic [31:0] addr,
                         input logic [31:0] data);
        bit ok;
        ok = 0;
        pc_in       = addr;
        pc_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (pc_in_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("fetch_timeout", 32'd0, 32'd1);
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        pc_in       = '0;
        pc_in_valid = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        mid();
        chk("rst_ready", 32'(pc_in_ready), 32'd1);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_err", 32'(instr_err), 32'd0);

        // single fetch, minimum latency
        tick();
        pc_in       = 32'h0000_0100;
        pc_in_valid = 1'b1;
        mid();
        chk("sf_ready", 32'(pc_in_ready), 32'd1);
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        mid();
        chk("sf_req", 32'(imem_req), 32'd1);
        chk("sf_addr", imem_addr, 32'h0000_0100);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        mid();
        chk("sf_early", 32'(instr_valid), 32'd0);
        tick();
        imem_rvalid = 1'b0;
        mid();
        chk("sf_valid", 32'(instr_valid), 32'd1);
        chk("sf_instr", instr, 32'hDEAD_BEEF);
        chk("sf_pc", instr_pc, 32'h0000_0100);
        chk("sf_err", 32'(instr_err), 32'd0);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        mid();
        chk("sf_popped", 32'(instr_valid), 32'd0);

        // backpressure with a two-entry buffer
        tick();
        fetch(32'h0, 32'hA000_0000);
        fetch(32'h4, 32'hA000_0004);
        pc_in       = 32'h8;
        pc_in_valid = 1'b1;
        mid();
        chk("bp_ready0", 32'(pc_in_ready), 32'd0);
        chk("bp_head0", instr_pc, 32'h0);
        chk("bp_instr0", instr, 32'hA000_0000);
        tick();
        mid();
        chk("bp_noreq", 32'(imem_req), 32'd0);
        tick();
        instr_ready = 1'b1;
        mid();
        chk("bp_ready1", 32'(pc_in_ready), 32'd0);
        tick();
        instr_ready = 1'b0;
        mid();
        chk("bp_ready2", 32'(pc_in_ready), 32'd1);
        chk("bp_head1", instr_pc, 32'h4);
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        mid();
        chk("bp_addr8", imem_addr, 32'h8);
        chk("bp_req8", 32'(imem_req), 32'd1);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_0008;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        mid();
        chk("bp_ord0", instr_pc, 32'h4);
        chk("bp_full", 32'(pc_in_ready), 32'd0);
        tick();
        mid();
        chk("bp_ord1", instr_pc, 32'h8);
        chk("bp_ord1i", instr, 32'hA000_0008);
        tick();
        instr_ready = 1'b0;
        mid();
        chk("bp_empty", 32'(instr_valid), 32'd0);

        // grant stall for five cycles
        tick();
        hs_base     = hs_cnt;
        pc_in       = 32'h0000_0200;
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("gs_req", 32'(imem_req), 32'd1);
            chk("gs_addr", imem_addr, 32'h0000_0200);
            tick();
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        mid();
        chk("gs_reqoff", 32'(imem_req), 32'd0);
        chk("gs_count", 32'(hs_cnt - hs_base), 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0200;
        tick();
        imem_rvalid = 1'b0;
        mid();
        chk("gs_instr", instr, 32'hCAFE_0200);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // flush one cycle after grant
        pc_in       = 32'h0000_0300;
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        mid();
        chk("fw_ready0", 32'(pc_in_ready), 32'd0);
        tick();
        flush = 1'b0;
        mid();
        chk("fw_drainreq", 32'(imem_req), 32'd0);
        chk("fw_drainrdy", 32'(pc_in_ready), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        mid();
        chk("fw_rdyrv", 32'(pc_in_ready), 32'd0);
        tick();
        imem_rvalid = 1'b0;
        mid();
        chk("fw_ready1", 32'(pc_in_ready), 32'd1);
        chk("fw_novalid", 32'(instr_valid), 32'd0);

        // misaligned PC
        tick();
        pc_in       = 32'h0000_0102;
        pc_in_valid = 1'b1;
        mid();
        chk("mis_ready", 32'(pc_in_ready), 32'd1);
        tick();
        pc_in_valid = 1'b0;
        mid();
        chk("mis_noreq", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(instr_valid), 32'd1);
        chk("mis_err", 32'(instr_err), 32'd1);
        chk("mis_pc", instr_pc, 32'h0000_0102);
        chk("mis_instr", instr, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // simultaneous push and pop with one entry buffered
        fetch(32'h0000_0400, 32'hB000_0400);
        pc_in       = 32'h0000_0404;
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hB000_0404;
        instr_ready = 1'b1;
        mid();
        chk("pp_head0", instr_pc, 32'h0000_0400);
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        mid();
        chk("pp_valid", 32'(instr_valid), 32'd1);
        chk("pp_head1", instr_pc, 32'h0000_0404);
        chk("pp_instr1", instr, 32'hB000_0404);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        mid();
        chk("pp_count1", 32'(instr_valid), 32'd0);

        // flush in IDLE with a buffered entry
        tick();
        fetch(32'h0000_0500, 32'hC000_0500);
        flush = 1'b1;
        mid();
        chk("fi_ready", 32'(pc_in_ready), 32'd0);
        tick();
        flush = 1'b0;
        mid();
        chk("fi_clear", 32'(instr_valid), 32'd0);

        // flush in REQ, without and with grant
        tick();
        pc_in       = 32'h0000_0600;
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("fr_drop", 32'(imem_req), 32'd0);
        chk("fr_idle", 32'(pc_in_ready), 32'd1);
        tick();
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        flush       = 1'b1;
        imem_gnt    = 1'b1;
        tick();
        flush    = 1'b0;
        imem_gnt = 1'b0;
        mid();
        chk("frg_drain", 32'(pc_in_ready), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0600;
        tick();
        imem_rvalid = 1'b0;
        mid();
        chk("frg_idle", 32'(pc_in_ready), 32'd1);
        chk("frg_novalid", 32'(instr_valid), 32'd0);

        // reset while waiting for read data
        tick();
        pc_in       = 32'h0000_0700;
        pc_in_valid = 1'b1;
        tick();
        pc_in_valid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        mid();
        chk("mr_ready", 32'(pc_in_ready), 32'd1);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, 32'd0);
        chk("mr_valid", 32'(instr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
